// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider handshake bundle.
// Execute drives the request side, the divider drives completion and result.
interface div_ctrl_if;
    logic        div_enable;
    logic        div_sign;
    logic        div_op_mod;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_accept;
    logic        div_cancel;
    logic        div_complete;
    logic [31:0] div_result;
    logic        div_busy;

    modport master (
        output div_enable, div_sign, div_op_mod,
        output div_src1, div_src2, div_accept, div_cancel,
        input  div_complete, div_result, div_busy
    );

    modport slave (
        input  div_enable, div_sign, div_op_mod,
        input  div_src1, div_src2, div_accept, div_cancel,
        output div_complete, div_result, div_busy
    );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// One quotient bit per cycle; result held in DONE until accepted.
module div_ctrl (
    input logic       clk,
    input logic       reset,
    div_ctrl_if.slave div
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, mod_q, neg1_q, neg2_q, zero_q;
    logic [31:0] dvd_q, dsr_q, result_q;
    logic [32:0] rem_q;
    logic [5:0]  cnt_q;

    logic        start, last;
    logic        neg1, neg2;
    logic [31:0] abs1, abs2;
    logic [33:0] shifted;
    logic [32:0] diff, rem_nx;
    logic        ge;
    logic [31:0] quo_nx, q_fix, r_fix, res_nx;

    assign start = div.div_enable & ~div.div_cancel;
    assign last  = (cnt_q == 6'd31);

    assign neg1 = div.div_sign & div.div_src1[31];
    assign neg2 = div.div_sign & div.div_src2[31];
    assign abs1 = neg1 ? -div.div_src1 : div.div_src1;
    assign abs2 = neg2 ? -div.div_src2 : div.div_src2;

    // Restoring step: keep the shifted remainder when the trial underflows
    assign shifted = {rem_q, dvd_q[31]};
    assign ge      = shifted >= {2'b00, dsr_q};
    assign diff    = shifted[32:0] - {1'b0, dsr_q};
    assign rem_nx  = ge ? diff : shifted[32:0];
    assign quo_nx  = {dvd_q[30:0], ge};

    always_comb begin
        q_fix = quo_nx;
        if (sign_q && (neg1_q ^ neg2_q))
            q_fix = -quo_nx;
        if (zero_q)
            q_fix = 32'hFFFF_FFFF;
        r_fix = (sign_q && neg1_q) ? -rem_nx[31:0] : rem_nx[31:0];
        res_nx = mod_q ? r_fix : q_fix;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: begin
                if (div.div_cancel)
                    state_d = IDLE;
                else if (last)
                    state_d = DONE;
            end
            DONE: begin
                if (div.div_cancel || div.div_accept)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q   <= 1'b0;
            mod_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            zero_q   <= 1'b0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                sign_q <= div.div_sign;
                mod_q  <= div.div_op_mod;
                neg1_q <= neg1;
                neg2_q <= neg2;
                zero_q <= (div.div_src2 == 32'd0);
                dvd_q  <= abs1;
                dsr_q  <= abs2;
                rem_q  <= '0;
                cnt_q  <= '0;
            end
        end else if (state_q == CALC) begin
            rem_q <= rem_nx;
            dvd_q <= quo_nx;
            cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
            if (state_d == DONE)
                result_q <= res_nx;
        end
    end

    assign div.div_complete = (state_q == DONE);
    assign div.div_busy     = (state_q != IDLE);
    assign div.div_result   = result_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed + randomized bench for div_ctrl against an arithmetic model.
// A cycle-level scoreboard checks busy/complete/result every cycle.
module tb_div_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_ctrl_if dif ();

    div_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .div   (dif.slave)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input bit s, input bit m);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return m ? a : 32'hFFFF_FFFF;
        if (!s)
            return m ? a % b : a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return m ? 32'd0 : 32'h8000_0000;
        return m ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Timing model: a request occupies 33 cycles before its result shows
    bit          m_active;
    int          m_age;
    logic [31:0] m_out, m_pend;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_age    = 0;
            m_out    = 32'd0;
        end else if (!m_active) begin
            if (dif.div_enable && !dif.div_cancel) begin
                m_active = 1'b1;
                m_age    = 1;
                m_pend   = ref_div(dif.div_src1, dif.div_src2,
                                   dif.div_sign, dif.div_op_mod);
            end
        end else if (dif.div_cancel) begin
            m_active = 1'b0;
        end else if (m_age == 33) begin
            if (dif.div_accept)
                m_active = 1'b0;
        end else begin
            m_age++;
            if (m_age == 33)
                m_out = m_pend;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("sb_busy", 32'(dif.div_busy), 32'(m_active));
            chk("sb_complete", 32'(dif.div_complete),
                32'(m_active && m_age == 33));
            chk("sb_result", dif.div_result, m_out);
        end
    end

    task automatic idle();
        @(negedge clk);
        dif.div_enable = 1'b0;
        dif.div_accept = 1'b0;
        dif.div_cancel = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input bit s, input bit m);
        @(negedge clk);
        dif.div_enable = 1'b1;
        dif.div_sign   = s;
        dif.div_op_mod = m;
        dif.div_src1   = a;
        dif.div_src2   = b;
        dif.div_accept = 1'b0;
        dif.div_cancel = 1'b0;
    endtask

    task automatic wait_done(input string name, input int drop_at);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (n < 40 && !done) begin
            @(posedge clk);
            #1;
            n++;
            done = dif.div_complete;
            if (n == drop_at)
                dif.div_enable = 1'b0;
        end
        chk({name, "_lat"}, 32'(n), 32'd33);
    endtask

    task automatic run(input string name, input logic [31:0] a,
                       input logic [31:0] b, input bit s, input bit m,
                       input logic [31:0] exp, input int hold);
        issue(a, b, s, m);
        wait_done(name, 0);
        chk(name, dif.div_result, exp);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk({name, "_hold_c"}, 32'(dif.div_complete), 32'd1);
            chk({name, "_hold_r"}, dif.div_result, exp);
        end
        @(negedge clk);
        dif.div_accept = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_acc"}, 32'(dif.div_busy), 32'd0);
    endtask

    logic [31:0] corner [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF,
                                32'h7FFF_FFFF, 32'h8000_0000};

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 2) == 0)
            return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        reset          = 1'b1;
        dif.div_enable = 1'b0;
        dif.div_sign   = 1'b0;
        dif.div_op_mod = 1'b0;
        dif.div_src1   = 32'd0;
        dif.div_src2   = 32'd0;
        dif.div_accept = 1'b0;
        dif.div_cancel = 1'b0;
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(dif.div_busy), 32'd0);
        chk("rst_complete", 32'(dif.div_complete), 32'd0);
        chk("rst_result", dif.div_result, 32'd0);
        reset = 1'b0;

        chk("pin_model_q", ref_div(32'hFFFF_FFF9, 32'd2, 1, 0), 32'hFFFF_FFFD);
        chk("pin_model_r", ref_div(32'd7, 32'hFFFF_FFFE, 1, 1), 32'd1);

        run("divu_100_7", 32'd100, 32'd7, 0, 0, 32'd14, 0);
        idle();
        run("modu_100_7", 32'd100, 32'd7, 0, 1, 32'd2, 0);
        idle();
        run("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1, 0, 32'hFFFF_FFFD, 0);
        idle();
        run("mod_m7_2", 32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFF, 0);
        idle();
        run("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1, 0, 32'hFFFF_FFFD, 0);
        idle();
        run("mod_7_m2", 32'd7, 32'hFFFF_FFFE, 1, 1, 32'd1, 0);
        idle();
        run("divw_by0", 32'h1234_5678, 32'd0, 1, 0, 32'hFFFF_FFFF, 0);
        idle();
        run("modwu_by0", 32'h1234_5678, 32'd0, 0, 1, 32'h1234_5678, 0);
        idle();
        run("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 0);
        idle();
        run("mod_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'd0, 0);
        idle();

        // Back-pressure, then an immediate second request
        run("bp_first", 32'd1000, 32'd9, 0, 0, 32'd111, 10);
        run("bp_second", 32'd1000, 32'd9, 0, 1, 32'd1, 0);
        idle();

        // Enable dropping mid-CALC does not abort
        issue(32'd50, 32'd5, 0, 0);
        wait_done("en_drop", 3);
        chk("en_drop", dif.div_result, 32'd10);
        @(negedge clk);
        dif.div_accept = 1'b1;
        idle();

        // Cancel at CALC cycle 10
        issue(32'd999, 32'd3, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        dif.div_cancel = 1'b1;
        @(posedge clk);
        #1;
        chk("cancel_busy", 32'(dif.div_busy), 32'd0);
        idle();
        repeat (40) @(posedge clk);
        #1;
        chk("cancel_nocomp", 32'(dif.div_complete), 32'd0);
        chk("cancel_hold", dif.div_result, 32'd10);

        // Reset while in DONE, then a request right after reset
        issue(32'd81, 32'd9, 0, 0);
        wait_done("rst_done", 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstd_busy", 32'(dif.div_busy), 32'd0);
        chk("rstd_complete", 32'(dif.div_complete), 32'd0);
        chk("rstd_result", dif.div_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dif.div_enable = 1'b0;
        run("post_rst", 32'd81, 32'd9, 0, 1, 32'd0, 0);
        idle();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            bit s, m;
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            run("rand", a, b, s, m, ref_div(a, b, s, m),
                $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                idle();
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
